// File: rtl/fcs_pkg.sv
// Shared types, constants and the byte-wide CRC-32 step for the FCS checker.
package fcs_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_CHECK,
        ST_ABORTED
    } fcs_state_e;

    localparam logic [31:0] CRC_SEED    = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_RESIDUE = 32'hC704_DD7B;
    localparam logic [31:0] CRC_POLY    = 32'h04C1_1DB7;
    localparam int unsigned FCS_BYTES   = 4;

    // Bit 0 of the byte enters the register first (LSB-first on air).
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc;
        for (int unsigned i = 0; i < 8; i++) begin
            c = {c[30:0], 1'b0} ^ ((c[31] ^ data[i]) ? CRC_POLY : 32'h0);
        end
        return c;
    endfunction

endpackage

// File: rtl/crc32_lfsr8.sv
// Byte-wide CRC-32 register; init reseeds so the byte taken in the same cycle starts a new frame.
module crc32_lfsr8
    import fcs_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic        init,
    input  logic        en,
    input  logic [7:0]  data_in,
    output logic [31:0] crc_out
);

    logic [31:0] crc_q, crc_d, base;

    always_comb begin
        base  = init ? CRC_SEED : crc_q;
        crc_d = en ? crc32_byte(base, data_in) : base;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            crc_q <= CRC_SEED;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc_out = crc_q;

endmodule

// File: rtl/fcs_check_ctrl.sv
// Frame check sequence controller: sequences CRC-32 checking and forwards the byte stream.
// Build option FCS_STRIP_EN holds back the trailing FCS bytes from the forwarded stream.
module fcs_check_ctrl
    import fcs_pkg::*;
#(
    parameter int unsigned MAX_LEN = 4095
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    input  logic        byte_last,
    input  logic        frame_abort,
    output logic        in_ready,
    output logic        fcs_valid,
    output logic        fcs_ok,
    output logic        len_err,
    output logic [15:0] frame_len,
    output logic [7:0]  byte_out,
    output logic        byte_out_valid,
    output logic        byte_out_last,
    output logic        busy
);

    fcs_state_e  state_q, state_d;
    logic [15:0] cnt_q, cnt_d, cnt_nxt;
    logic [15:0] frame_len_q, frame_len_d;
    logic [7:0]  bo_q, bo_d;
    logic        bov_q, bov_d, bol_q, bol_d;
    logic        first, accept, too_long, take;
    logic        fwd_vld, fwd_last;
    logic [7:0]  fwd_byte;
    logic [31:0] crc;
`ifdef FCS_STRIP_EN
    logic [FCS_BYTES-1:0][7:0] dl_q, dl_d;
    logic [FCS_BYTES-1:0]      dlv_q, dlv_d;
`endif

    assign in_ready = (state_q == ST_IDLE) || (state_q == ST_ACCUM);
    assign first    = (state_q == ST_IDLE);
    assign accept   = byte_valid && in_ready;
    assign cnt_nxt  = first ? 16'd1 : cnt_q + 16'd1;
    assign too_long = 32'(cnt_nxt) > MAX_LEN;
    // A byte handshaked alongside an abort or an overflow is discarded.
    assign take     = accept && !frame_abort && !too_long;

    crc32_lfsr8 u_crc (
        .clk     (clk),
        .rstn    (rstn),
        .init    (first),
        .en      (take),
        .data_in (byte_in),
        .crc_out (crc)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        frame_len_d = frame_len_q;
        if (frame_abort) begin
            state_d = ST_ABORTED;
        end else begin
            case (state_q)
                ST_IDLE, ST_ACCUM: begin
                    if (accept) begin
                        if (too_long) begin
                            state_d = ST_ABORTED;
                        end else begin
                            cnt_d = cnt_nxt;
                            if (byte_last) begin
                                state_d     = ST_CHECK;
                                frame_len_d = cnt_nxt;
                            end else begin
                                state_d = ST_ACCUM;
                            end
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
        if (state_q == ST_CHECK || state_q == ST_ABORTED) begin
            cnt_d = '0;
        end
    end

    always_comb begin
        fwd_vld  = 1'b0;
        fwd_last = 1'b0;
        fwd_byte = byte_in;
`ifdef FCS_STRIP_EN
        dl_d  = dl_q;
        dlv_d = dlv_q;
        if (state_q == ST_CHECK || state_q == ST_ABORTED) begin
            dlv_d = '0;
        end
        // Emit the byte taken FCS_BYTES bytes ago; the last FCS_BYTES never leave.
        if (take) begin
            dl_d     = {dl_q[FCS_BYTES-2:0], byte_in};
            dlv_d    = first ? {{(FCS_BYTES-1){1'b0}}, 1'b1} : {dlv_q[FCS_BYTES-2:0], 1'b1};
            fwd_vld  = !first && dlv_q[FCS_BYTES-1];
            fwd_byte = dl_q[FCS_BYTES-1];
            fwd_last = byte_last;
        end
`else
        if (take) begin
            fwd_vld  = 1'b1;
            fwd_last = byte_last;
        end
`endif
        bov_d = fwd_vld;
        bol_d = fwd_vld && fwd_last;
        bo_d  = fwd_vld ? fwd_byte : bo_q;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            frame_len_q <= '0;
            bo_q        <= '0;
            bov_q       <= 1'b0;
            bol_q       <= 1'b0;
`ifdef FCS_STRIP_EN
            dl_q        <= '0;
            dlv_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            frame_len_q <= frame_len_d;
            bo_q        <= bo_d;
            bov_q       <= bov_d;
            bol_q       <= bol_d;
`ifdef FCS_STRIP_EN
            dl_q        <= dl_d;
            dlv_q       <= dlv_d;
`endif
        end
    end

    assign fcs_valid      = (state_q == ST_CHECK);
    assign len_err        = fcs_valid && (frame_len_q < 16'(FCS_BYTES));
    assign fcs_ok         = fcs_valid && !len_err && (crc == CRC_RESIDUE);
    assign frame_len      = frame_len_q;
    assign byte_out       = bo_q;
    assign byte_out_valid = bov_q;
    assign byte_out_last  = bol_q;
    assign busy           = (state_q != ST_IDLE);

endmodule

// File: tb/tb_fcs_check_ctrl.sv
// Directed and randomized bench for fcs_check_ctrl against a reflected-CRC frame model.
module tb_fcs_check_ctrl;

    localparam int TB_MAX = 16;

    typedef logic [7:0] bq_t[$];
    typedef struct packed {
        logic        ok;
        logic        lerr;
        logic [15:0] len;
    } res_t;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [7:0]  byte_in = '0;
    logic        byte_valid = 1'b0;
    logic        byte_last = 1'b0;
    logic        frame_abort = 1'b0;
    logic        in_ready, fcs_valid, fcs_ok, len_err;
    logic [15:0] frame_len;
    logic [7:0]  byte_out;
    logic        byte_out_valid, byte_out_last, busy;

    int   checks = 0;
    int   errors = 0;
    int   last_stall = 0;
    int   last_len = 0;
    res_t res_q[$];
    logic [8:0] out_q[$];
    bq_t  good, bad, f;

    fcs_check_ctrl #(.MAX_LEN(TB_MAX)) dut (
        .clk            (clk),
        .rstn           (rstn),
        .byte_in        (byte_in),
        .byte_valid     (byte_valid),
        .byte_last      (byte_last),
        .frame_abort    (frame_abort),
        .in_ready       (in_ready),
        .fcs_valid      (fcs_valid),
        .fcs_ok         (fcs_ok),
        .len_err        (len_err),
        .frame_len      (frame_len),
        .byte_out       (byte_out),
        .byte_out_valid (byte_out_valid),
        .byte_out_last  (byte_out_last),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rstn) begin
            if (fcs_valid) res_q.push_back(res_t'({fcs_ok, len_err, frame_len}));
            if (byte_out_valid) out_q.push_back({byte_out_last, byte_out});
        end
    end

    // Standard reflected CRC-32 with final inversion (the value that goes on air as the FCS).
    function automatic logic [31:0] crc32_ref(input bq_t d, input int n);
        logic [31:0] c;
        c = '1;
        for (int i = 0; i < n; i++) begin
            c = c ^ {24'h0, d[i]};
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        return ~c;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic make_frame(input int plen, input bit ok, output bq_t fr);
        logic [31:0] c;
        fr = {};
        for (int i = 0; i < plen; i++) fr.push_back(8'($urandom));
        c = crc32_ref(fr, plen);
        if (ok) begin
            fr.push_back(c[7:0]);
            fr.push_back(c[15:8]);
            fr.push_back(c[23:16]);
            fr.push_back(c[31:24]);
        end else begin
            for (int i = 0; i < 4; i++) fr.push_back(8'($urandom));
        end
    endtask

    // cut >= 0 stops after byte index cut, asserting frame_abort on it when abort_on_cut.
    task automatic send_frame(input bq_t d, input int cut, input bit abort_on_cut, input bit hold);
        int n;
        int guard;
        n = (cut >= 0) ? cut + 1 : d.size();
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            byte_valid  = 1'b1;
            byte_in     = d[i];
            byte_last   = (i == d.size() - 1);
            frame_abort = abort_on_cut && (i == cut);
            guard = 0;
            while (!in_ready && guard < 8) begin
                @(negedge clk);
                guard++;
            end
            if (i == 0) last_stall = guard;
            if (guard == 8) chk("ready_timeout", 32'(in_ready), 32'(1));
        end
        if (!hold) begin
            @(negedge clk);
            byte_valid  = 1'b0;
            byte_last   = 1'b0;
            frame_abort = 1'b0;
        end
    endtask

    task automatic check_frame(input string tag, input bq_t d, input int taken, input bit completed);
        res_t r;
        int   n;
        int   nf;
        logic exp_ok;
        repeat (4) @(negedge clk);
        n = d.size();
        if (completed) begin
            exp_ok = 1'b0;
            if (n >= 4) exp_ok = (crc32_ref(d, n - 4) == {d[n-1], d[n-2], d[n-3], d[n-4]});
            chk({tag, "_strobe"}, 32'(res_q.size() > 0), 32'(1));
            if (res_q.size() > 0) begin
                r = res_q.pop_front();
                chk({tag, "_ok"}, 32'(r.ok), 32'(exp_ok));
                chk({tag, "_lenerr"}, 32'(r.lerr), 32'(n < 4));
                chk({tag, "_len"}, 32'(r.len), 32'(n));
                last_len = n;
            end
        end
`ifdef FCS_STRIP_EN
        nf = (taken > 4) ? taken - 4 : 0;
`else
        nf = taken;
`endif
        for (int i = 0; i < nf; i++) begin
            if (out_q.size() == 0) begin
                chk({tag, "_outcnt"}, 32'(i), 32'(nf));
                break;
            end
            chk({tag, "_byte"}, 32'(out_q.pop_front()), 32'({completed && (i == nf - 1), d[i]}));
        end
    endtask

    task automatic group_end(input string tag);
        chk({tag, "_extra_strobe"}, 32'(res_q.size()), 32'(0));
        chk({tag, "_extra_bytes"}, 32'(out_q.size()), 32'(0));
        res_q.delete();
        out_q.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_fcs_valid"}, 32'(fcs_valid), 32'(0));
        chk({tag, "_fcs_ok"}, 32'(fcs_ok), 32'(0));
        chk({tag, "_len_err"}, 32'(len_err), 32'(0));
        chk({tag, "_bo_valid"}, 32'(byte_out_valid), 32'(0));
        chk({tag, "_bo_last"}, 32'(byte_out_last), 32'(0));
        chk({tag, "_busy"}, 32'(busy), 32'(0));
        chk({tag, "_frame_len"}, 32'(frame_len), 32'(0));
        chk({tag, "_byte_out"}, 32'(byte_out), 32'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog");
    end

    initial begin
        good = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
                 8'h26, 8'h39, 8'hF4, 8'hCB};
        bad = good;
        bad[4] = 8'h34;

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        chk("reset_in_ready", 32'(in_ready), 32'(1));
        rstn = 1'b1;

        send_frame(good, -1, 1'b0, 1'b0);
        check_frame("good", good, good.size(), 1'b1);
        group_end("good");

        send_frame(bad, -1, 1'b0, 1'b0);
        check_frame("bad", bad, bad.size(), 1'b1);
        group_end("bad");

        f = '{8'hAA, 8'hBB, 8'hCC};
        send_frame(f, -1, 1'b0, 1'b0);
        check_frame("short3", f, 3, 1'b1);
        group_end("short3");

        f = '{8'h5A};
        send_frame(f, -1, 1'b0, 1'b0);
        check_frame("single", f, 1, 1'b1);
        group_end("single");

        send_frame(good, 5, 1'b1, 1'b0);
        check_frame("abort", good, 5, 1'b0);
        group_end("abort");
        chk("abort_len_hold", 32'(frame_len), 32'(last_len));
        send_frame(good, -1, 1'b0, 1'b0);
        check_frame("after_abort", good, good.size(), 1'b1);
        group_end("after_abort");

        send_frame(good, -1, 1'b0, 1'b1);
        send_frame(good, -1, 1'b0, 1'b0);
        chk("b2b_bubble", 32'(last_stall), 32'(1));
        check_frame("b2b_a", good, good.size(), 1'b1);
        check_frame("b2b_b", good, good.size(), 1'b1);
        group_end("b2b");

        make_frame(TB_MAX - 4, 1'b1, f);
        send_frame(f, -1, 1'b0, 1'b0);
        check_frame("max_len", f, f.size(), 1'b1);
        group_end("max_len");

        make_frame(TB_MAX - 3, 1'b1, f);
        send_frame(f, -1, 1'b0, 1'b0);
        check_frame("over_len", f, TB_MAX, 1'b0);
        group_end("over_len");
        chk("over_len_hold", 32'(frame_len), 32'(last_len));

        for (int k = 0; k < 24; k++) begin
            if ($urandom_range(0, 5) == 0) begin
                f = {};
                for (int i = 0; i < int'($urandom_range(1, 3)); i++) f.push_back(8'($urandom));
            end else begin
                make_frame(int'($urandom_range(0, TB_MAX - 4)), 1'($urandom_range(0, 1)), f);
            end
            send_frame(f, -1, 1'b0, 1'b0);
            check_frame("rand", f, f.size(), 1'b1);
            group_end("rand");
        end

        send_frame(good, 4, 1'b0, 1'b0);
        chk("mid_busy", 32'(busy), 32'(1));
        rstn = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        @(negedge clk);
        rstn = 1'b1;
        res_q.delete();
        out_q.delete();
        send_frame(good, -1, 1'b0, 1'b0);
        check_frame("post_reset", good, good.size(), 1'b1);
        group_end("post_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
